// File: rtl/lab8_soc_pio_gen.sv
// lab8_soc_pio_gen: parametrised Avalon-MM general-purpose I/O slave.
// Per-bit direction, atomic set/clear of output bits, a two-flop input
// synchroniser, sticky edge capture and a maskable level interrupt.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    word address (0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP, 4 OUTSET, 5 OUTCLR)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data, bits above WIDTH-1 ignored
//   readdata   combinational read data, zero-extended, 0 when not selected
//   in_port    asynchronous external inputs
//   out_port   output data register
//   oe         per-bit output enable (direction register)
//   irq        registered level interrupt, active high
module lab8_soc_pio_gen #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '0,
  parameter int unsigned     EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic             irq_q;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] edge_now;
  logic [WIDTH-1:0] rd_val;
  logic             unused_writedata;

  assign wr_en = chipselect & ~write_n;
  assign wd    = writedata[WIDTH-1:0];
  // Upper writedata bits are intentionally dropped.
  assign unused_writedata = ^writedata;

  always_comb begin
    if (EDGE_MODE == 0) begin
      edge_now = sync2_q & ~prev_q;
    end else if (EDGE_MODE == 1) begin
      edge_now = ~sync2_q & prev_q;
    end else begin
      edge_now = sync2_q ^ prev_q;
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (wr_en) begin
      case (address)
        3'd0:    data_out_d = wd;
        3'd1:    dir_d      = wd;
        3'd2:    irq_mask_d = wd;
        3'd3:    edge_cap_d = edge_cap_q & ~wd;
        3'd4:    data_out_d = data_out_q | wd;
        3'd5:    data_out_d = data_out_q & ~wd;
        default: ;
      endcase
    end
    // A new edge in the same cycle as a write-1-to-clear keeps the bit set.
    edge_cap_d = edge_cap_d | edge_now;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      dir_q      <= RESET_DIR;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      irq_q      <= |(edge_cap_q & irq_mask_q);
    end
  end

  always_comb begin
    rd_val = '0;
    if (chipselect) begin
      case (address)
        3'd0:    rd_val = (dir_q & data_out_q) | (~dir_q & sync2_q);
        3'd1:    rd_val = dir_q;
        3'd2:    rd_val = irq_mask_q;
        3'd3:    rd_val = edge_cap_q;
        default: rd_val = '0;
      endcase
    end
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_val;
  end

  assign out_port = data_out_q;
  assign oe       = dir_q;
  assign irq      = irq_q;

endmodule
